// File: rtl/gate_sensor_sequencer.sv
// gate_sensor_sequencer
//   Front end of the garage occupancy counter. Two IR beams at the gate
//   (A = outer/street side, B = inner/garage side) are synchronised and
//   debounced. An FSM then turns the beam sequence into one-cycle car_in /
//   car_out pulses that feed the BCD occupancy counter's up/down inputs.
//   Entries are refused with a deny pulse while the garage is full. The FSM
//   also drives the gate and reports its own state.
//
//   state | meaning
//   ------+---------------------------------------------------------
//   IDLE  | both beams clear, no car in the gate
//   EN1   | entering: A blocked only
//   EN2   | entering: A and B blocked
//   EN3   | entering: B blocked only
//   EX1   | leaving:  B blocked only
//   EX2   | leaving:  A and B blocked
//   EX3   | leaving:  A blocked only
//   CLR   | abandoned or refused sequence, waiting for both beams to clear
//
// Ports
//   clk        system clock
//   reset      synchronous, active-low reset
//   sens_a     raw outer beam, 1 = blocked, asynchronous
//   sens_b     raw inner beam, 1 = blocked, asynchronous
//   full       occupancy counter at capacity
//   empty      occupancy counter at zero
//   car_in     one-cycle pulse, one entry completed
//   car_out    one-cycle pulse, one exit completed
//   deny       one-cycle pulse, entry refused (garage full)
//   gate_open  gate actuator, 1 = open (EN1..EX3)
//   busy       1 whenever state != IDLE
//   state      current FSM state code
module gate_sensor_sequencer #(
    parameter int DB_CYCLES = 4,
    parameter int TIMEOUT   = 1000,
    parameter int TMR_W     = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sens_a,
    input  logic       sens_b,
    input  logic       full,
    input  logic       empty,
    output logic       car_in,
    output logic       car_out,
    output logic       deny,
    output logic       gate_open,
    output logic       busy,
    output logic [2:0] state
);

    localparam int DB_W = $clog2(DB_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_EN1  = 3'd1,
        S_EN2  = 3'd2,
        S_EN3  = 3'd3,
        S_EX1  = 3'd4,
        S_EX2  = 3'd5,
        S_EX3  = 3'd6,
        S_CLR  = 3'd7
    } state_t;

    // Beam vectors: bit 1 = beam A, bit 0 = beam B.
    logic [1:0]      sync1_q, sync1_d;
    logic [1:0]      sync2_q, sync2_d;
    logic [1:0]      db_q, db_d;
    logic [DB_W-1:0] db_cnt_q [2];
    logic [DB_W-1:0] db_cnt_d [2];

    state_t          state_q, state_d;
    logic [TMR_W-1:0] tmr_q, tmr_d;
    logic            car_in_q, car_in_d;
    logic            car_out_q, car_out_d;
    logic            deny_q, deny_d;
    logic            gate_open_q, gate_open_d;
    logic            busy_q, busy_d;

    logic            a, b;
    logic            in_seq;

    // Debounce: the count runs only while the synced sample disagrees with
    // the debounced value; the flip happens on the edge that would make the
    // count reach DB_CYCLES.
    always_comb begin
        sync1_d = {sens_a, sens_b};
        sync2_d = sync1_q;
        db_d    = db_q;
        for (int i = 0; i < 2; i++) begin
            db_cnt_d[i] = '0;
            if (sync2_q[i] != db_q[i]) begin
                if (db_cnt_q[i] == DB_W'(DB_CYCLES - 1)) begin
                    db_d[i] = sync2_q[i];
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + DB_W'(1);
                end
            end
        end
    end

    assign a      = db_q[1];
    assign b      = db_q[0];
    assign in_seq = (state_q != S_IDLE) && (state_q != S_CLR);

    always_comb begin
        state_d   = state_q;
        car_in_d  = 1'b0;
        car_out_d = 1'b0;
        deny_d    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (a && !b) begin
                    if (full) begin
                        state_d = S_CLR;
                        deny_d  = 1'b1;
                    end else begin
                        state_d = S_EN1;
                    end
                end else if (!a && b) begin
                    state_d = S_EX1;
                end else if (a && b) begin
                    state_d = S_CLR;
                end
            end
            S_EN1: begin
                if (a && b)        state_d = S_EN2;
                else if (!a && !b) state_d = S_IDLE;
                else if (!a && b)  state_d = S_CLR;
            end
            S_EN2: begin
                if (!a && b)       state_d = S_EN3;
                else if (a && !b)  state_d = S_EN1;
                else if (!a && !b) state_d = S_CLR;
            end
            S_EN3: begin
                if (!a && !b) begin
                    state_d = S_IDLE;
                    // Capacity can be reached while this car was in the gate.
                    if (full) deny_d   = 1'b1;
                    else      car_in_d = 1'b1;
                end else if (a && b) begin
                    state_d = S_EN2;
                end else if (a && !b) begin
                    // Both beams changed at once: not a plausible car.
                    state_d = S_CLR;
                end
            end
            S_EX1: begin
                if (a && b)        state_d = S_EX2;
                else if (!a && !b) state_d = S_IDLE;
                else if (a && !b)  state_d = S_CLR;
            end
            S_EX2: begin
                if (a && !b)       state_d = S_EX3;
                else if (!a && b)  state_d = S_EX1;
                else if (!a && !b) state_d = S_CLR;
            end
            S_EX3: begin
                if (!a && !b) begin
                    state_d = S_IDLE;
                    // An exit reported at zero would underflow the counter.
                    car_out_d = !empty;
                end else if (a && b) begin
                    state_d = S_EX2;
                end else if (!a && b) begin
                    state_d = S_CLR;
                end
            end
            S_CLR: begin
                if (!a && !b) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // A beam transition always wins over the stall abort.
        tmr_d = '0;
        if (in_seq && (state_d == state_q)) begin
            if (tmr_q == TMR_W'(TIMEOUT - 1)) begin
                state_d = S_CLR;
            end else begin
                tmr_d = tmr_q + TMR_W'(1);
            end
        end

        gate_open_d = (state_d != S_IDLE) && (state_d != S_CLR);
        busy_d      = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            sync1_q     <= '0;
            sync2_q     <= '0;
            db_q        <= '0;
            db_cnt_q[0] <= '0;
            db_cnt_q[1] <= '0;
            state_q     <= S_IDLE;
            tmr_q       <= '0;
            car_in_q    <= 1'b0;
            car_out_q   <= 1'b0;
            deny_q      <= 1'b0;
            gate_open_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            db_q        <= db_d;
            db_cnt_q[0] <= db_cnt_d[0];
            db_cnt_q[1] <= db_cnt_d[1];
            state_q     <= state_d;
            tmr_q       <= tmr_d;
            car_in_q    <= car_in_d;
            car_out_q   <= car_out_d;
            deny_q      <= deny_d;
            gate_open_q <= gate_open_d;
            busy_q      <= busy_d;
        end
    end

    assign car_in    = car_in_q;
    assign car_out   = car_out_q;
    assign deny      = deny_q;
    assign gate_open = gate_open_q;
    assign busy      = busy_q;
    assign state     = state_q;

endmodule

// File: tb/tb_gate_sensor_sequencer.sv
// Testbench for gate_sensor_sequencer: directed gate scenarios plus random
// beam traffic, all compared cycle by cycle against a reference model that
// tracks a car's progress along the A/B beam path.
module tb_gate_sensor_sequencer;

    localparam int DB_CYCLES = 4;
    localparam int TIMEOUT   = 50;
    localparam int TMR_W     = 10;

    localparam int M_IDLE = 0;
    localparam int M_SEQ  = 1;
    localparam int M_CLR  = 2;

    logic       clk    = 1'b0;
    logic       reset  = 1'b0;
    logic       sens_a = 1'b0;
    logic       sens_b = 1'b0;
    logic       full   = 1'b0;
    logic       empty  = 1'b0;
    logic       car_in, car_out, deny, gate_open, busy;
    logic [2:0] state;
    logic [7:0] obs;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    gate_sensor_sequencer #(
        .DB_CYCLES(DB_CYCLES),
        .TIMEOUT  (TIMEOUT),
        .TMR_W    (TMR_W)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .sens_a   (sens_a),
        .sens_b   (sens_b),
        .full     (full),
        .empty    (empty),
        .car_in   (car_in),
        .car_out  (car_out),
        .deny     (deny),
        .gate_open(gate_open),
        .busy     (busy),
        .state    (state)
    );

    assign obs = {state, car_in, car_out, deny, gate_open, busy};

    // Reference model. A sequence is a direction (0 = in, 1 = out) and a
    // step 1..3 along the beam path 00 -> 10 -> 11 -> 01 -> 00, with the
    // beams read as {A,B} for entries and {B,A} for exits.
    int   m_mode, m_dir, m_step, m_age;
    bit   [1:0] m_s1, m_s2, m_db;
    int   m_run [2];
    bit   m_in, m_out, m_deny;

    function automatic logic [1:0] path_pat(input int k);
        case (k)
            1:       return 2'b10;
            2:       return 2'b11;
            3:       return 2'b01;
            default: return 2'b00;
        endcase
    endfunction

    always @(posedge clk) begin : ref_model
        bit a, b;
        logic [1:0] pat;
        if (!reset) begin
            m_mode = M_IDLE; m_dir = 0; m_step = 0; m_age = 0;
            m_s1 = 0; m_s2 = 0; m_db = 0; m_run[0] = 0; m_run[1] = 0;
            m_in = 0; m_out = 0; m_deny = 0;
        end else begin
            a = m_db[1];
            b = m_db[0];
            m_in = 0; m_out = 0; m_deny = 0;
            case (m_mode)
                M_IDLE: begin
                    if (a && !b) begin
                        if (full) begin m_mode = M_CLR; m_deny = 1; end
                        else begin m_mode = M_SEQ; m_dir = 0; m_step = 1; m_age = 1; end
                    end else if (!a && b) begin
                        m_mode = M_SEQ; m_dir = 1; m_step = 1; m_age = 1;
                    end else if (a && b) begin
                        m_mode = M_CLR;
                    end
                end
                M_SEQ: begin
                    pat = (m_dir == 0) ? {a, b} : {b, a};
                    if (pat == path_pat(m_step)) begin
                        if (m_age >= TIMEOUT) m_mode = M_CLR;
                        else m_age++;
                    end else if (pat == path_pat(m_step + 1)) begin
                        if (m_step == 3) begin
                            m_mode = M_IDLE;
                            if (m_dir == 0) begin
                                if (full) m_deny = 1; else m_in = 1;
                            end else if (!empty) begin
                                m_out = 1;
                            end
                        end else begin
                            m_step++; m_age = 1;
                        end
                    end else if (pat == path_pat(m_step - 1)) begin
                        if (m_step == 1) m_mode = M_IDLE;
                        else begin m_step--; m_age = 1; end
                    end else begin
                        m_mode = M_CLR;
                    end
                end
                default: if (!a && !b) m_mode = M_IDLE;
            endcase
            for (int i = 0; i < 2; i++) begin
                if (m_s2[i] != m_db[i]) begin
                    m_run[i]++;
                    if (m_run[i] == DB_CYCLES) begin m_db[i] = m_s2[i]; m_run[i] = 0; end
                end else begin
                    m_run[i] = 0;
                end
            end
            m_s2 = m_s1;
            m_s1 = {sens_a, sens_b};
        end
    end

    function automatic logic [7:0] exp_vec();
        int sc;
        if (m_mode == M_IDLE)     sc = 0;
        else if (m_mode == M_CLR) sc = 7;
        else                      sc = (m_dir == 0) ? m_step : 3 + m_step;
        return {sc[2:0], m_in, m_out, m_deny, 1'(m_mode == M_SEQ), 1'(m_mode != M_IDLE)};
    endfunction

    task automatic test_reset();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            tests++;
            if (obs !== 8'h00) begin
                $display("FAIL reset_outputs cycle %0d: got %b want %b", i, obs, 8'h00);
                fails++;
            end
        end
        reset = 1'b1;
    endtask

    // Directed phases of constant beams; tallies pulses and the state path.
    task automatic run_phases(input string name, input bit pa [], input bit pb [],
                              input int len, output int n_in, output int n_out,
                              output int n_deny, output int path, output int n_s1);
        logic [2:0] last;
        n_in = 0; n_out = 0; n_deny = 0; path = 0; n_s1 = 0; last = 3'd0;
        for (int p = 0; p < pa.size(); p++) begin
            sens_a = pa[p];
            sens_b = pb[p];
            for (int i = 0; i < len; i++) begin
                @(negedge clk);
                tests++;
                if (obs !== exp_vec()) begin
                    $display("FAIL %s phase %0d cycle %0d: got %b want %b", name, p, i, obs, exp_vec());
                    fails++;
                end
                n_in += int'(car_in);
                n_out += int'(car_out);
                n_deny += int'(deny);
                if (state == 3'd1) n_s1++;
                if (state !== last) begin
                    path = path * 8 + int'(state);
                    last = state;
                end
            end
        end
    endtask

    task automatic test_clean_entry();
        int n_in, n_out, n_deny, path, n_s1;
        full = 0; empty = 0;
        run_phases("clean_entry", '{1, 1, 0, 0}, '{0, 1, 1, 0}, 10, n_in, n_out, n_deny, path, n_s1);
        tests++;
        if (path != ((1 * 8 + 2) * 8 + 3) * 8 + 0) begin
            $display("FAIL entry_path: got %0o want %0o", path, ((1 * 8 + 2) * 8 + 3) * 8);
            fails++;
        end
        tests++;
        if (n_in != 1 || n_out != 0 || n_deny != 0) begin
            $display("FAIL entry_pulses: got in=%0d out=%0d deny=%0d want 1/0/0", n_in, n_out, n_deny);
            fails++;
        end
    endtask

    task automatic test_bounce();
        int bad = 0;
        full = 0; empty = 0;
        for (int i = 0; i < 18; i++) begin
            sens_a = (i < 3) ? bit'(i % 2 == 0) : 1'b0;
            sens_b = 1'b0;
            @(negedge clk);
            tests++;
            if (obs !== exp_vec()) begin
                $display("FAIL bounce cycle %0d: got %b want %b", i, obs, exp_vec());
                fails++;
            end
            if (obs !== 8'h00) bad++;
        end
        tests++;
        if (bad != 0) begin
            $display("FAIL bounce_idle: got %0d non-idle cycles want 0", bad);
            fails++;
        end
    endtask

    task automatic test_full();
        int n_in, n_out, n_deny, path, n_s1;
        full = 1; empty = 0;
        run_phases("full", '{1, 0}, '{0, 0}, 10, n_in, n_out, n_deny, path, n_s1);
        full = 0;
        tests++;
        if (path != 7 * 8 + 0) begin
            $display("FAIL full_path: got %0o want %0o", path, 7 * 8);
            fails++;
        end
        tests++;
        if (n_deny != 1 || n_in != 0) begin
            $display("FAIL full_pulses: got deny=%0d in=%0d want 1/0", n_deny, n_in);
            fails++;
        end
    endtask

    task automatic test_exit(input bit emp);
        int n_in, n_out, n_deny, path, n_s1;
        full = 0; empty = emp;
        run_phases(emp ? "exit_empty" : "exit", '{0, 1, 1, 0}, '{1, 1, 0, 0}, 10,
                   n_in, n_out, n_deny, path, n_s1);
        tests++;
        if (path != ((4 * 8 + 5) * 8 + 6) * 8 + 0) begin
            $display("FAIL exit_path: got %0o want %0o", path, ((4 * 8 + 5) * 8 + 6) * 8);
            fails++;
        end
        tests++;
        if (n_out != (emp ? 0 : 1) || n_in != 0 || n_deny != 0) begin
            $display("FAIL exit_pulses empty=%0d: got out=%0d in=%0d deny=%0d want %0d/0/0",
                     emp, n_out, n_in, n_deny, emp ? 0 : 1);
            fails++;
        end
        empty = 0;
    endtask

    task automatic test_stall();
        int n_in, n_out, n_deny, path, n_s1;
        full = 0; empty = 0;
        run_phases("stall_hold", '{1}, '{0}, 60, n_in, n_out, n_deny, path, n_s1);
        tests++;
        if (n_s1 != TIMEOUT) begin
            $display("FAIL stall_dwell: got %0d cycles in EN1 want %0d", n_s1, TIMEOUT);
            fails++;
        end
        tests++;
        if (state !== 3'd7) begin
            $display("FAIL stall_abort: got state %0d want 7", state);
            fails++;
        end
        run_phases("stall_release", '{0}, '{0}, 12, n_in, n_out, n_deny, path, n_s1);
        tests++;
        if (state !== 3'd0 || n_in + n_out + n_deny != 0) begin
            $display("FAIL stall_release: got state %0d pulses %0d want 0/0", state, n_in + n_out + n_deny);
            fails++;
        end
    endtask

    task automatic test_reset_mid();
        int n_in, n_out, n_deny, path, n_s1;
        int waited = 0;
        full = 0; empty = 0;
        run_phases("mid_a", '{1}, '{0}, 8, n_in, n_out, n_deny, path, n_s1);
        sens_b = 1'b1;
        while (state !== 3'd2 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        tests++;
        if (state !== 3'd2) begin
            $display("FAIL mid_reach_en2: got state %0d want 2 within 20 cycles", state);
            fails++;
        end
        reset = 1'b0;
        @(negedge clk);
        tests++;
        if (obs !== 8'h00) begin
            $display("FAIL mid_reset: got %b want %b", obs, 8'h00);
            fails++;
        end
        reset = 1'b1;
        run_phases("mid_release", '{0}, '{0}, 15, n_in, n_out, n_deny, path, n_s1);
        tests++;
        if (n_in + n_out + n_deny != 0) begin
            $display("FAIL mid_no_pulse: got %0d pulses want 0", n_in + n_out + n_deny);
            fails++;
        end
    endtask

    task automatic test_random();
        for (int e = 0; e < 30; e++) begin
            int nph;
            nph = $urandom_range(1, 6);
            for (int p = 0; p <= nph; p++) begin
                int len;
                if (p == nph) begin
                    sens_a = 1'b0; sens_b = 1'b0; len = 14;
                end else begin
                    sens_a = 1'($urandom_range(0, 1));
                    sens_b = 1'($urandom_range(0, 1));
                    len = ($urandom_range(0, 7) == 0) ? 60 : int'($urandom_range(1, 12));
                end
                full  = ($urandom_range(0, 2) == 0);
                empty = ($urandom_range(0, 3) == 0);
                for (int i = 0; i < len; i++) begin
                    @(negedge clk);
                    tests++;
                    if (obs !== exp_vec()) begin
                        $display("FAIL random ep %0d phase %0d cycle %0d: got %b want %b",
                                 e, p, i, obs, exp_vec());
                        fails++;
                    end
                    tests++;
                    if ($countones({car_in, car_out, deny}) > 1) begin
                        $display("FAIL pulse_exclusive ep %0d: got %b want at most one", e,
                                 {car_in, car_out, deny});
                        fails++;
                    end
                end
            end
        end
        full = 0; empty = 0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish want finish before 1 ms");
        $fatal(1, "watchdog expired");
    end

    initial begin
        @(negedge clk);
        test_reset();
        test_clean_entry();
        test_bounce();
        test_full();
        test_exit(1'b1);
        test_exit(1'b0);
        test_stall();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
